// File: rtl/alu_pkg.sv
// Shared definitions for the 74181-style ALU slice: function-select codes for
// both modes, the mode encoding, the registered output bundle and its reset
// value.
package alu_pkg;

    // Mode select values on M
    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // Carry-in polarity: Cn is active-low, so 0 adds one
    localparam logic CN_CARRY    = 1'b0;
    localparam logic CN_NO_CARRY = 1'b1;

    // Arithmetic functions (M=0), shown for Cn=1; each gets +1 when Cn=0
    localparam logic [3:0] ARITH_A                    = 4'b0000;
    localparam logic [3:0] ARITH_A_OR_B               = 4'b0001;
    localparam logic [3:0] ARITH_A_OR_NB              = 4'b0010;
    localparam logic [3:0] ARITH_MINUS_1              = 4'b0011;
    localparam logic [3:0] ARITH_A_PLUS_A_AND_NB      = 4'b0100;
    localparam logic [3:0] ARITH_AORB_PLUS_A_AND_NB   = 4'b0101;
    localparam logic [3:0] ARITH_A_MINUS_B_MINUS_1    = 4'b0110;
    localparam logic [3:0] ARITH_A_AND_NB_MINUS_1     = 4'b0111;
    localparam logic [3:0] ARITH_A_PLUS_A_AND_B       = 4'b1000;
    localparam logic [3:0] ARITH_A_PLUS_B             = 4'b1001;
    localparam logic [3:0] ARITH_AORNB_PLUS_A_AND_B   = 4'b1010;
    localparam logic [3:0] ARITH_A_AND_B_MINUS_1      = 4'b1011;
    localparam logic [3:0] ARITH_A_PLUS_A             = 4'b1100;
    localparam logic [3:0] ARITH_AORB_PLUS_A          = 4'b1101;
    localparam logic [3:0] ARITH_AORNB_PLUS_A         = 4'b1110;
    localparam logic [3:0] ARITH_A_MINUS_1            = 4'b1111;

    // Logic functions (M=1); the carry plays no part
    localparam logic [3:0] LOGIC_NOT_A        = 4'b0000;
    localparam logic [3:0] LOGIC_NOR          = 4'b0001;
    localparam logic [3:0] LOGIC_NA_AND_B     = 4'b0010;
    localparam logic [3:0] LOGIC_ZERO         = 4'b0011;
    localparam logic [3:0] LOGIC_NAND         = 4'b0100;
    localparam logic [3:0] LOGIC_NOT_B        = 4'b0101;
    localparam logic [3:0] LOGIC_XOR          = 4'b0110;
    localparam logic [3:0] LOGIC_A_AND_NB     = 4'b0111;
    localparam logic [3:0] LOGIC_NA_OR_B      = 4'b1000;
    localparam logic [3:0] LOGIC_XNOR         = 4'b1001;
    localparam logic [3:0] LOGIC_B            = 4'b1010;
    localparam logic [3:0] LOGIC_AND          = 4'b1011;
    localparam logic [3:0] LOGIC_ONES         = 4'b1100;
    localparam logic [3:0] LOGIC_A_OR_NB      = 4'b1101;
    localparam logic [3:0] LOGIC_OR           = 4'b1110;
    localparam logic [3:0] LOGIC_A            = 4'b1111;

    // Registered output bundle; G, P and Cn4 are active-low
    typedef struct packed {
        logic [3:0] f;
        logic       aeb;
        logic       g;
        logic       p;
        logic       cn4;
    } alu_out_t;

    // Inactive levels: zero result, no compare hit, no generate/propagate/carry
    localparam logic [3:0] F_RESET   = 4'b0000;
    localparam logic       AEB_RESET = 1'b0;
    localparam logic       G_RESET   = 1'b1;
    localparam logic       P_RESET   = 1'b1;
    localparam logic       CN4_RESET = 1'b1;

    localparam alu_out_t OUT_RESET = '{
        f:   F_RESET,
        aeb: AEB_RESET,
        g:   G_RESET,
        p:   P_RESET,
        cn4: CN4_RESET
    };

endpackage : alu_pkg

// File: rtl/alu181_core.sv
// Combinational 74181 core in the active-high data convention. Each bit first
// forms X (propagate) and Y (generate) from A, B and S; arithmetic adds X+Y+carry
// through a 4-bit lookahead chain, logic mode inverts the carry-free half-sum.
module alu181_core
    import alu_pkg::*;
(
    input  logic [3:0] s_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       m_i,
    input  logic       cn_i,
    output logic [3:0] f_o,
    output logic       aeb_o,
    output logic       g_o,
    output logic       p_o,
    output logic       cn4_o
);

    logic [3:0] x;       // per-bit propagate
    logic [3:0] y;       // per-bit generate; y[i] implies x[i]
    logic [3:0] half;    // carry-free sum bit X^Y
    logic [3:0] carry;   // carry into each bit, active-high
    logic       c0;
    logic       gg;      // group generate, active-high
    logic       pg;      // group propagate, active-high
    logic       c4;      // carry out of bit 3, active-high
    logic [3:0] f_arith;
    logic [3:0] f_logic;
    logic [3:0] f_sel;

    // Per-bit operand shaping selected by S
    always_comb begin
        // NOTE: every variable gets a value on every path through a comb block,
        // otherwise synthesis has to infer a latch to hold the old value.
        x = '0;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            x[i] = a_i[i] | (b_i[i] & s_i[0]) | (~b_i[i] & s_i[1]);
            y[i] = (a_i[i] & ~b_i[i] & s_i[2]) | (a_i[i] & b_i[i] & s_i[3]);
        end
    end

    // Carry lookahead: each internal carry is a flat sum of products from c0
    always_comb begin
        c0 = ~cn_i;
        carry[0] = c0;
        carry[1] = y[0]
                 | (x[0] & c0);
        carry[2] = y[1]
                 | (x[1] & y[0])
                 | (x[1] & x[0] & c0);
        carry[3] = y[2]
                 | (x[2] & y[1])
                 | (x[2] & x[1] & y[0])
                 | (x[2] & x[1] & x[0] & c0);
        gg = y[3]
           | (x[3] & y[2])
           | (x[3] & x[2] & y[1])
           | (x[3] & x[2] & x[1] & y[0]);
        pg = &x;
        c4 = gg | (pg & c0);
    end

    // Result selection: arithmetic sum or inverted half-sum for logic mode
    always_comb begin
        half    = x ^ y;
        f_arith = half ^ carry;
        f_logic = ~half;
        f_sel   = (m_i == MODE_LOGIC) ? f_logic : f_arith;
    end

    // Output drive; lookahead outputs are independent of M
    always_comb begin
        f_o   = f_sel;
        aeb_o = (f_sel == 4'b1111);
        g_o   = ~gg;
        p_o   = ~pg;
        cn4_o = ~c4;
    end

endmodule : alu181_core

// File: rtl/alu.sv
// Clocked 74181 slice: the combinational core feeds a bank of output registers,
// so results appear one cycle after the inputs are sampled.
module alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] S,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       M,
    input  logic       Cn,
    output logic [3:0] F,
    output logic       AeB,
    output logic       G,
    output logic       Cn4,
    output logic       P
);

    alu_out_t out_d;
    alu_out_t out_q;

    alu181_core u_core (
        .s_i   (S),
        .a_i   (A),
        .b_i   (B),
        .m_i   (M),
        .cn_i  (Cn),
        .f_o   (out_d.f),
        .aeb_o (out_d.aeb),
        .g_o   (out_d.g),
        .p_o   (out_d.p),
        .cn4_o (out_d.cn4)
    );

    // Output register bank; reset forces every output to its inactive level
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values; the async reset sits in the sensitivity list so it
        // acts without a clock edge.
        if (rst) begin
            out_q <= OUT_RESET;
        end else begin
            out_q <= out_d;
        end
    end

    // Unpack the registered bundle onto the pins
    always_comb begin
        F   = out_q.f;
        AeB = out_q.aeb;
        G   = out_q.g;
        P   = out_q.p;
        Cn4 = out_q.cn4;
    end

endmodule : alu

// File: tb/tb_alu.sv
// Bench for the clocked 74181 slice: directed cases with hand-worked values,
// a mid-stream reset, then every S/A/B/M/Cn combination against a model built
// from the X/Y, sum and lookahead equations.
module tb_alu;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] S;
    logic [3:0] A;
    logic [3:0] B;
    logic       M;
    logic       Cn;
    logic [3:0] F;
    logic       AeB;
    logic       G;
    logic       Cn4;
    logic       P;

    int total = 0;
    int bad   = 0;

    alu_out_t sb[$];

    alu dut (
        .clk (clk),
        .rst (rst),
        .S   (S),
        .A   (A),
        .B   (B),
        .M   (M),
        .Cn  (Cn),
        .F   (F),
        .AeB (AeB),
        .G   (G),
        .Cn4 (Cn4),
        .P   (P)
    );

    always #5 clk = ~clk;

    function automatic alu_out_t model(input logic [3:0] s, input logic [3:0] a,
                                       input logic [3:0] b, input logic m,
                                       input logic cn);
        logic [3:0] x;
        logic [3:0] y;
        logic [4:0] sum;
        logic       gen;
        logic       prop;
        alu_out_t   r;
        for (int i = 0; i < 4; i++) begin
            x[i] = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
            y[i] = (a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]);
        end
        sum  = {1'b0, x} + {1'b0, y} + {4'b0000, ~cn};
        gen  = y[3] | (x[3] & y[2]) | (x[3] & x[2] & y[1]) | (x[3] & x[2] & x[1] & y[0]);
        prop = x[3] & x[2] & x[1] & x[0];
        r.f   = m ? ~(x ^ y) : sum[3:0];
        r.aeb = (r.f == 4'b1111);
        r.g   = ~gen;
        r.p   = ~prop;
        r.cn4 = ~(gen | (prop & ~cn));
        return r;
    endfunction

    function automatic logic [7:0] observed();
        return {F, AeB, G, P, Cn4};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs and queue the result they should produce one edge later
    task automatic drive(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b,
                         input logic m, input logic cn);
        S  = s;
        A  = a;
        B  = b;
        M  = m;
        Cn = cn;
        sb.push_back(model(s, a, b, m, cn));
    endtask

    // Advance one edge and compare the registered outputs with the oldest entry
    task automatic sample(input string tag);
        alu_out_t exp;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, observed());
        end else begin
            exp = sb.pop_front();
            check(tag, observed(), exp);
        end
    endtask

    // Compare against values worked out by hand
    task automatic expect_lit(input string tag, input logic [3:0] f, input logic aeb,
                              input logic g, input logic p, input logic cn4);
        check({tag, "_lit"}, observed(), {f, aeb, g, p, cn4});
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        sb.delete();
        #1;
        expect_lit("por", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        #11;
        expect_lit("por_hold", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;

        // Transfer A, with and without carry-in
        drive(ARITH_A, 4'b0010, 4'b0110, MODE_ARITH, CN_NO_CARRY);
        sample("xfer");
        expect_lit("xfer", 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(ARITH_A, 4'b0010, 4'b0110, MODE_ARITH, CN_CARRY);
        sample("xfer_c");
        expect_lit("xfer_c", 4'b0011, 1'b0, 1'b1, 1'b1, 1'b1);

        // Subtract / compare
        drive(ARITH_A_MINUS_B_MINUS_1, 4'b0110, 4'b0101, MODE_ARITH, CN_NO_CARRY);
        sample("sub");
        expect_lit("sub", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(ARITH_A_MINUS_B_MINUS_1, 4'b0101, 4'b0101, MODE_ARITH, CN_NO_CARRY);
        sample("cmp_eq");
        expect_lit("cmp_eq", 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1);

        // Overflow cases
        drive(ARITH_A_PLUS_A, 4'b1111, 4'b1111, MODE_ARITH, CN_NO_CARRY);
        sample("dbl_ovf");
        expect_lit("dbl_ovf", 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(ARITH_A_PLUS_B, 4'b1010, 4'b0110, MODE_ARITH, CN_CARRY);
        sample("add_ovf");
        expect_lit("add_ovf", 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);

        // Logic functions, then carry toggle with logic mode
        drive(LOGIC_XNOR, 4'b1010, 4'b0110, MODE_LOGIC, CN_NO_CARRY);
        sample("xnor");
        expect_lit("xnor", 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(LOGIC_XOR, 4'b1010, 4'b0110, MODE_LOGIC, CN_NO_CARRY);
        sample("xor");
        expect_lit("xor", 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(LOGIC_ZERO, 4'b1010, 4'b0110, MODE_LOGIC, CN_NO_CARRY);
        sample("zero");
        expect_lit("zero", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(LOGIC_ONES, 4'b1010, 4'b0110, MODE_LOGIC, CN_NO_CARRY);
        sample("ones");
        expect_lit("ones", 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(LOGIC_XNOR, 4'b1010, 4'b0110, MODE_LOGIC, CN_CARRY);
        sample("xnor_c");
        expect_lit("xnor_c", 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);

        // Inputs changing between edges must not reach the outputs
        drive(LOGIC_ZERO, 4'b0001, 4'b0010, MODE_LOGIC, CN_NO_CARRY);
        #3;
        expect_lit("mid_hold", 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
        sample("after_hold");
        expect_lit("after_hold", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Mid-stream reset: clears without an edge, holds, drops the in-flight op
        drive(ARITH_A_PLUS_B, 4'b0111, 4'b0111, MODE_ARITH, CN_NO_CARRY);
        sample("pre_rst");
        expect_lit("pre_rst", 4'b1110, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(LOGIC_ONES, 4'b0101, 4'b0011, MODE_LOGIC, CN_NO_CARRY);
        #3;
        rst = 1'b1;
        #1;
        expect_lit("rst_async", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        expect_lit("rst_hold", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        sb.delete();
        #2;
        rst = 1'b0;
        drive(ARITH_A, 4'b0010, 4'b0110, MODE_ARITH, CN_NO_CARRY);
        sample("post_rst");
        expect_lit("post_rst", 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1);

        // Every combination of S, A, B, M, Cn
        for (int v = 0; v < 16384; v++) begin
            logic [13:0] vec;
            vec = v[13:0];
            drive(vec[13:10], vec[9:6], vec[5:2], vec[1], vec[0]);
            sample($sformatf("exh_%0d", v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu
